fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the fixed PC register and direct instruction-memory hookup with a prefetching fetch unit. It generates sequential fetch addresses, tolerates variable-latency instruction memory through a req/ack handshake, and buffers fetched words in a DEPTH-entry FIFO. It presents instructions to decode with a valid/ready handshake and supports redirect (branch/jump) flush with discard of in-flight stale responses. It sits between the instruction memory and the decode stage of the pipelined core.

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: sequential PC generation, req/ack memory
// handshake, DEPTH-entry {word, addr} FIFO toward decode, redirect flush with stale-ack drop.
module fetch_queue #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready,
    output logic             err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {FETCH, DROP} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] drop_addr_q, drop_addr_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] addr_q [DEPTH];

    logic full;
    logic push;
    logic pop;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign instr_valid = (count_q != '0);
    assign instr       = word_q[rd_ptr_q];
    assign instr_pc    = addr_q[rd_ptr_q];
    assign err         = err_q;
    assign push        = (state_q == FETCH) && imem_req && imem_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q[wr_ptr_q] <= imem_data;
            addr_q[wr_ptr_q] <= pc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (redirect && imem_req && !imem_ack) state_d = DROP;
            DROP:    if (imem_ack) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // An issued request is held (pend_q) even if halt rises; halt only gates new requests.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (state_q == DROP) begin
            imem_req  = 1'b1;
            imem_addr = drop_addr_q;
        end else begin
            imem_req = pend_q || (!halt && !full);
        end
        if (rst) imem_req = 1'b0;
    end

    always_comb begin
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        pend_d      = pend_q;
        err_d       = err_q | (imem_ack & ~imem_req);
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (state_q == FETCH && imem_req) begin
            pend_d = !imem_ack;
            if (imem_ack) pc_d = pc_q + PC_STEP;
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            pc_d     = redirect_pc;
            pend_d   = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            if (state_q == FETCH) drop_addr_d = pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: behavioural memory with programmable latency, expected
// {pc, word} pushed per issued fetch, a negedge monitor pops and compares on each accept.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          lat = 0;
    int          wcnt = 0;
    logic        force_ack = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(
        .WIDTH   (16),
        .DEPTH   (4),
        .RESET_PC(16'h0000),
        .PC_STEP (16'h0002)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .err        (err)
    );

    // Memory: acks after `lat` waiting cycles; returns addr ^ 16'hA5A5.
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack  = 1'b1;
            imem_data = 16'hDEAD;
        end else if (imem_req === 1'b1) begin
            if (wcnt >= lat) begin
                imem_ack  = 1'b1;
                imem_data = imem_addr ^ 16'hA5A5;
                wcnt      = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && instr_valid === 1'b1 && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got pc=%h instr=%h, expected no word", instr_pc, instr);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (instr_pc !== e || instr !== (e ^ 16'hA5A5)) begin
                    errors++;
                    $display("FAIL word_order: got pc=%h instr=%h, expected pc=%h instr=%h",
                             instr_pc, instr, e, e ^ 16'hA5A5);
                end
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step(2);
        @(negedge clk);
        chk1 ("rst_req",   imem_req,    1'b0);
        chk1 ("rst_valid", instr_valid, 1'b0);
        chk16("rst_addr",  imem_addr,   16'h0000);
        chk1 ("rst_err",   err,         1'b0);

        // Zero-wait streaming: pcs 0..10, one per cycle
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(2 * i));
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk1 ("first_req",   imem_req,    1'b1);
        chk16("first_addr",  imem_addr,   16'h0000);
        chk1 ("first_valid", instr_valid, 1'b0);
        step(1);
        @(negedge clk);
        chk16("stream_addr1",  imem_addr,   16'h0002);
        chk1 ("stream_valid1", instr_valid, 1'b1);
        step(4);
        @(negedge clk);
        chk16("stream_addr5", imem_addr, 16'h000A);
        step(1);
        halt = 1'b1;
        @(negedge clk);
        chk1("halt_req", imem_req, 1'b0);
        step(4);
        @(negedge clk);
        chk1("stream_err", err, 1'b0);

        // Backpressure: FIFO fills to 4, then drains in order and fetch resumes at 20
        step(1);
        instr_ready = 1'b0;
        halt = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(12 + 2 * i));
        step(6);
        @(negedge clk);
        chk1 ("full_req",   imem_req,    1'b0);
        chk1 ("full_valid", instr_valid, 1'b1);
        chk16("full_head",  instr_pc,    16'h000C);
        step(1);
        instr_ready = 1'b1;
        @(negedge clk);
        chk1("release_req", imem_req, 1'b0);
        step(1);
        @(negedge clk);
        chk1 ("resume_req",  imem_req,  1'b1);
        chk16("resume_addr", imem_addr, 16'h0014);
        step(1);
        halt = 1'b1;
        step(6);

        // Delayed memory, redirect during wait: stale ack dropped
        lat = 3;
        halt = 1'b0;
        @(negedge clk);
        chk16("wait_addr0", imem_addr, 16'h0016);
        step(1);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        chk16("wait_addr1", imem_addr, 16'h0016);
        step(1);
        redirect = 1'b0;
        @(negedge clk);
        chk1 ("drop_req",   imem_req,    1'b1);
        chk16("drop_addr",  imem_addr,   16'h0016);
        chk1 ("drop_valid", instr_valid, 1'b0);
        step(1);
        @(negedge clk);
        chk16("drop_ack_addr", imem_addr, 16'h0016);
        step(1);
        lat = 0;
        exp_q.push_back(16'h0100);
        @(negedge clk);
        chk16("redir_addr",  imem_addr,   16'h0100);
        chk1 ("redir_valid", instr_valid, 1'b0);
        step(1);
        halt = 1'b1;
        @(negedge clk);
        chk16("redir_head", instr_pc, 16'h0100);
        step(3);

        // Redirect coinciding with an ack while two words are buffered
        instr_ready = 1'b0;
        halt = 1'b0;
        exp_q.push_back(16'h0200);
        step(2);
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        @(negedge clk);
        chk1("pre_flush_valid", instr_valid, 1'b1);
        step(1);
        redirect = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk1 ("flush_valid", instr_valid, 1'b0);
        chk16("flush_addr",  imem_addr,   16'h0200);
        step(1);
        halt = 1'b1;
        step(3);

        // halt raised while a request waits
        lat = 2;
        halt = 1'b0;
        exp_q.push_back(16'h0202);
        @(negedge clk);
        chk16("hw_addr0", imem_addr, 16'h0202);
        step(1);
        halt = 1'b1;
        @(negedge clk);
        chk1 ("hw_req1",  imem_req,  1'b1);
        chk16("hw_addr1", imem_addr, 16'h0202);
        step(1);
        @(negedge clk);
        chk1("hw_req2", imem_req, 1'b1);
        step(1);
        @(negedge clk);
        chk1 ("hw_req3",  imem_req,    1'b0);
        chk16("hw_head",  instr_pc,    16'h0202);
        step(1);
        @(negedge clk);
        chk1("hw_req4", imem_req, 1'b0);
        step(1);
        halt = 1'b0;
        lat = 0;
        exp_q.push_back(16'h0204);
        @(negedge clk);
        chk16("hw_resume_addr", imem_addr, 16'h0204);
        step(1);
        halt = 1'b1;
        step(3);

        // Address wrap at 0xFFFE
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step(1);
        redirect = 1'b0;
        halt = 1'b0;
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        chk16("wrap_addr0", imem_addr, 16'hFFFE);
        step(1);
        @(negedge clk);
        chk16("wrap_addr1", imem_addr, 16'h0000);
        step(1);
        halt = 1'b1;
        step(3);

        // Unsolicited ack -> sticky err, cleared by reset
        @(negedge clk);
        chk1("pre_err", err, 1'b0);
        step(1);
        force_ack = 1'b1;
        step(1);
        force_ack = 1'b0;
        @(negedge clk);
        chk1("err_set",      err,         1'b1);
        chk1("err_no_push",  instr_valid, 1'b0);
        step(3);
        @(negedge clk);
        chk1("err_sticky", err, 1'b1);
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk1 ("rst2_err",   err,         1'b0);
        chk1 ("rst2_req",   imem_req,    1'b0);
        chk16("rst2_addr",  imem_addr,   16'h0000);
        chk1 ("rst2_valid", instr_valid, 1'b0);
        step(2);
        rst = 1'b0;
        halt = 1'b0;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        chk1 ("rst2_first_req",  imem_req,  1'b1);
        chk16("rst2_first_addr", imem_addr, 16'h0000);
        step(1);
        halt = 1'b1;
        step(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained: got %0d pending words expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
